// File: rtl/xmss_thash_f.sv
// xmss_thash_f
//
// XMSS chaining-function controller for n = 32 (SHA-256). A call computes
//     key  = PRF(pub_seed, addr with keyAndMask = 0)
//     mask = PRF(pub_seed, addr with keyAndMask = 1)
//     out  = F(key, M ^ mask)
// by issuing three sequential requests to an external two-block SHA-256
// wrapper through a hash_start / hash_done handshake.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             one-cycle call request, honoured only when idle
//   input_key         pub_seed
//   input_data        message M
//   hash_addr         XMSS address, word 0 at [255:224], word 7 at [31:0]
//   data_out          registered result, held until the next completed call
//   busy, done        call in progress / one-cycle completion pulse
//   hash_start        one-cycle request to the hash unit
//   hash_data_in      1024-bit hash message buffer, 96 bytes in [1023:256]
//   message_length    always 0 (96-byte message)
//   hash_done         hash completion pulse, hash_data_out valid with it
//   hash_data_out     hash digest
module xmss_thash_f #(
    parameter int XMSS_HASH_PADDING_F   = 0,
    parameter int XMSS_HASH_PADDING_PRF = 3,
    parameter int KEY_LEN               = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KEY_LEN-1:0]   input_key,
    input  logic [KEY_LEN-1:0]   input_data,
    input  logic [255:0]         hash_addr,
    output logic [KEY_LEN-1:0]   data_out,
    output logic                 busy,
    output logic                 done,
    input  logic                 hash_done,
    input  logic [KEY_LEN-1:0]   hash_data_out,
    output logic                 hash_start,
    output logic [1023:0]        hash_data_in,
    output logic                 message_length
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PRF_KEY  = 2'd1;
    localparam logic [1:0] S_PRF_MASK = 2'd2;
    localparam logic [1:0] S_F_HASH   = 2'd3;

    localparam logic [255:0] PAD_F   = 256'(unsigned'(XMSS_HASH_PADDING_F));
    localparam logic [255:0] PAD_PRF = 256'(unsigned'(XMSS_HASH_PADDING_PRF));

    logic [1:0]          state_q,        state_d;
    logic [KEY_LEN-1:0]  seed_q,         seed_d;
    logic [KEY_LEN-1:0]  msg_q,          msg_d;
    logic [255:0]        addr_q,         addr_d;
    logic [KEY_LEN-1:0]  key_q,          key_d;
    logic [KEY_LEN-1:0]  mask_q,         mask_d;
    logic [KEY_LEN-1:0]  data_out_q,     data_out_d;
    logic                busy_q,         busy_d;
    logic                done_q,         done_d;
    logic                hash_start_q,   hash_start_d;
    logic [1023:0]       hash_data_in_q, hash_data_in_d;

    // Next-state logic: every buffer is built one cycle ahead so that it is
    // already stable in the cycle hash_start is raised.
    always_comb begin
        state_d        = state_q;
        seed_d         = seed_q;
        msg_d          = msg_q;
        addr_d         = addr_q;
        key_d          = key_q;
        mask_d         = mask_q;
        data_out_d     = data_out_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        hash_start_d   = 1'b0;
        hash_data_in_d = hash_data_in_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    seed_d         = input_key;
                    msg_d          = input_data;
                    addr_d         = hash_addr;
                    state_d        = S_PRF_KEY;
                    busy_d         = 1'b1;
                    hash_start_d   = 1'b1;
                    // addr_k: keyAndMask word forced to 0
                    hash_data_in_d = {PAD_PRF, input_key, hash_addr[255:32], 32'd0, 256'd0};
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_PRF_KEY: begin
                if (hash_done) begin
                    key_d          = hash_data_out;
                    state_d        = S_PRF_MASK;
                    hash_start_d   = 1'b1;
                    // addr_m: keyAndMask word forced to 1
                    hash_data_in_d = {PAD_PRF, seed_q, addr_q[255:32], 32'd1, 256'd0};
                end else begin
                    state_d = S_PRF_KEY;
                end
            end
            S_PRF_MASK: begin
                if (hash_done) begin
                    mask_d         = hash_data_out;
                    state_d        = S_F_HASH;
                    hash_start_d   = 1'b1;
                    // mask arrives this cycle, so mix it straight from the bus
                    hash_data_in_d = {PAD_F, key_q, msg_q ^ hash_data_out, 256'd0};
                end else begin
                    state_d = S_PRF_MASK;
                end
            end
            S_F_HASH: begin
                if (hash_done) begin
                    data_out_d = hash_data_out;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_F_HASH;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            seed_q         <= '0;
            msg_q          <= '0;
            addr_q         <= 256'd0;
            key_q          <= '0;
            mask_q         <= '0;
            data_out_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            hash_start_q   <= 1'b0;
            hash_data_in_q <= 1024'd0;
        end else begin
            state_q        <= state_d;
            seed_q         <= seed_d;
            msg_q          <= msg_d;
            addr_q         <= addr_d;
            key_q          <= key_d;
            mask_q         <= mask_d;
            data_out_q     <= data_out_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            hash_start_q   <= hash_start_d;
            hash_data_in_q <= hash_data_in_d;
        end
    end

    assign data_out       = data_out_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign hash_start     = hash_start_q;
    assign hash_data_in   = hash_data_in_q;
    assign message_length = 1'b0;

endmodule

// File: tb/tb_xmss_thash_f.sv
module tb_xmss_thash_f;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [255:0]  input_key;
    logic [255:0]  input_data;
    logic [255:0]  hash_addr;
    logic [255:0]  data_out;
    logic          busy;
    logic          done;
    logic          hash_done;
    logic [255:0]  hash_data_out;
    logic          hash_start;
    logic [1023:0] hash_data_in;
    logic          message_length;

    always #5 clk = ~clk;

    xmss_thash_f dut (
        .clk(clk), .reset(reset), .start(start),
        .input_key(input_key), .input_data(input_data), .hash_addr(hash_addr),
        .data_out(data_out), .busy(busy), .done(done),
        .hash_done(hash_done), .hash_data_out(hash_data_out),
        .hash_start(hash_start), .hash_data_in(hash_data_in),
        .message_length(message_length)
    );

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int stub_idx = 0;
    logic last_hd = 1'b0;
    logic [255:0] r_key, r_mask, r_f;
    logic [1023:0] exp_buf[$];
    logic [255:0]  exp_out[$];

    task automatic chk(input string name, input logic ok,
                       input logic [1023:0] act, input logic [1023:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [1023:0] mkbuf(input logic [255:0] pad,
                                            input logic [255:0] a,
                                            input logic [255:0] b);
        return {pad, a, b, 256'd0};
    endfunction

    // Hash stub: answers each request 3 cycles after hash_start.
    initial begin
        hash_done = 1'b0;
        hash_data_out = 256'd0;
        forever begin
            @(negedge clk);
            if (hash_start && !reset) begin
                logic [255:0] r;
                r = (stub_idx == 0) ? r_key : (stub_idx == 1) ? r_mask : r_f;
                stub_idx++;
                repeat (3) @(posedge clk);
                #1 hash_done = 1'b1;
                hash_data_out = r;
                @(posedge clk);
                #1 hash_done = 1'b0;
            end
        end
    end

    // Monitor: pops expected buffers / results whenever the DUT presents them.
    initial begin
        logic [1023:0] e;
        logic [255:0]  o;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("message_length", message_length == 1'b0, message_length, 1'b0);
                if (hash_start) begin
                    if (exp_buf.size() == 0) begin
                        chk("unexpected_hash_start", 1'b0, hash_start, 1'b0);
                    end else begin
                        e = exp_buf.pop_front();
                        chk("hash_data_in", hash_data_in === e, hash_data_in, e);
                    end
                    if (hs_cnt > 0) chk("hash_start_after_hash_done", last_hd, last_hd, 1'b1);
                    hs_cnt++;
                end
                if (done) begin
                    if (exp_out.size() == 0) begin
                        chk("unexpected_done", 1'b0, done, 1'b0);
                    end else begin
                        o = exp_out.pop_front();
                        chk("data_out", data_out === o, data_out, o);
                    end
                    chk("busy_at_done", busy == 1'b0, busy, 1'b0);
                    chk("hash_start_count", hs_cnt == 3, hs_cnt, 3);
                    hs_cnt = 0;
                end
            end
            last_hd = hash_done;
        end
    end

    task automatic push_call(input logic [255:0] k, input logic [255:0] d,
                             input logic [255:0] a);
        stub_idx = 0;
        exp_buf.push_back(mkbuf(256'd3, k, {a[255:32], 32'd0}));
        exp_buf.push_back(mkbuf(256'd3, k, {a[255:32], 32'd1}));
        exp_buf.push_back(mkbuf(256'd0, r_key, d ^ r_mask));
    endtask

    task automatic issue_start(input logic [255:0] k, input logic [255:0] d,
                               input logic [255:0] a);
        @(posedge clk);
        #1 start = 1'b1;
        input_key = k; input_data = d; hash_addr = a;
        @(posedge clk);
        #1 start = 1'b0;
        // scramble inputs: the call must use the captured copies
        input_key = ~k; input_data = k; hash_addr = ~a;
        @(negedge clk);
        chk("busy_after_start", busy == 1'b1, busy, 1'b1);
    endtask

    task automatic run_call(input logic [255:0] k, input logic [255:0] d,
                            input logic [255:0] a, input logic [255:0] rk,
                            input logic [255:0] rm, input logic [255:0] rf,
                            input bit extra_start);
        bit got;
        r_key = rk; r_mask = rm; r_f = rf;
        push_call(k, d, a);
        exp_out.push_back(rf);
        issue_start(k, d, a);
        if (extra_start) begin
            repeat (2) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_timeout", got, got, 1'b1);
    endtask

    localparam logic [255:0] ADDR0 =
        256'h0000_0001_0000_0002_0000_0003_0000_0004_0000_0005_0000_0006_0000_0007_0000_0009;

    initial begin
        bit got;
        reset = 1'b1; start = 1'b0;
        input_key = 256'd0; input_data = 256'd0; hash_addr = 256'd0;
        r_key = {32{8'hAA}}; r_mask = {32{8'h55}}; r_f = {32{8'h0F}};
        @(posedge clk);
        @(negedge clk);
        chk("rst_data_out", data_out == 256'd0, data_out, 256'd0);
        chk("rst_busy", busy == 1'b0, busy, 1'b0);
        chk("rst_done", done == 1'b0, done, 1'b0);
        chk("rst_hash_start", hash_start == 1'b0, hash_start, 1'b0);
        chk("rst_hash_data_in", hash_data_in == 1024'd0, hash_data_in, 1024'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Buffer test from the reference vectors, with a start pulse while busy.
        run_call({32{8'h11}}, {32{8'hFF}}, ADDR0,
                 {32{8'hAA}}, {32{8'h55}}, {32{8'h0F}}, 1'b1);
        // Back-to-back calls with distinct data.
        run_call({8{32'hDEAD_BEEF}}, {16{16'h1234}}, {8{32'hCAFE_F00D}},
                 {8{32'h0123_4567}}, {8{32'h89AB_CDEF}}, {8{32'h5A5A_A5A5}}, 1'b0);
        run_call(256'd1, ~256'd0, 256'hFFFF_FFFF, 256'd0, ~256'd0,
                 {4{64'h0011_2233_4455_6677}}, 1'b0);

        // Abort during PRF_MASK.
        r_key = {32{8'h3C}}; r_mask = {32{8'hC3}}; r_f = {32{8'h99}};
        push_call({32{8'h22}}, {32{8'h44}}, ADDR0);
        issue_start({32{8'h22}}, {32{8'h44}}, ADDR0);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hs_cnt == 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("reach_prf_mask", got, got, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_buf.delete();
        hs_cnt = 0;
        @(negedge clk);
        chk("abort_busy", busy == 1'b0, busy, 1'b0);
        chk("abort_done", done == 1'b0, done, 1'b0);
        chk("abort_data_out", data_out == 256'd0, data_out, 256'd0);
        // pending stub hash_done lands in IDLE; monitor flags any done/hash_start
        repeat (10) @(negedge clk);

        run_call({32{8'h5E}}, {32{8'hA1}}, {8{32'h0000_0042}},
                 {32{8'h77}}, {32{8'h88}}, {32{8'h12}}, 1'b0);
        run_call({32{8'h01}}, {32{8'h02}}, ADDR0,
                 {32{8'h10}}, {32{8'h20}}, {32{8'h30}}, 1'b0);

        repeat (3) @(negedge clk);
        chk("exp_buf_drained", exp_buf.size() == 0, exp_buf.size(), 0);
        chk("exp_out_drained", exp_out.size() == 0, exp_out.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
